// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler: shares one QIF update datapath across N_NEURONS
// virtual neurons. It keeps the membrane voltages in a local register file.
// Each accepted step walks neuron 0..N-1 through the datapath over a
// req/ack handshake. Each result then goes through the spike/reset rule, and
// the spike flags of the finished step are published on spike_vec.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable, step      step request, accepted in IDLE only while enable is high
//   clear             in IDLE, reloads VINIT into all slots and clears spike_vec
//   i_syn_flat        packed signed synaptic currents, slot k at [k*W +: W]
//   busy, done        step in progress / one-cycle completion pulse
//   spike_vec         spike flags of the last completed step
//   v_mem_flat        live view of the voltage register file (same packing)
//   dp_req/dp_v/dp_i  request and operands to the shared datapath
//   dp_ack/dp_v_next  datapath result handshake
module qif_neuron_scheduler #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned W         = 8,
    parameter int          VPEAK     = 50,
    parameter int          VRESET    = -20,
    parameter int          VINIT     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   step,
    input  logic                   clear,
    input  logic [N_NEURONS*W-1:0] i_syn_flat,
    output logic                   busy,
    output logic                   done,
    output logic [N_NEURONS-1:0]   spike_vec,
    output logic [N_NEURONS*W-1:0] v_mem_flat,
    output logic                   dp_req,
    output logic [W-1:0]           dp_v,
    output logic [W-1:0]           dp_i,
    input  logic                   dp_ack,
    input  logic [W-1:0]           dp_v_next
);

    localparam int unsigned KW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic signed [W-1:0] VPEAK_S  = W'(VPEAK);
    localparam logic signed [W-1:0] VRESET_S = W'(VRESET);
    localparam logic signed [W-1:0] VINIT_S  = W'(VINIT);
    localparam logic [KW-1:0]       K_LAST   = KW'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [KW-1:0]          k_q;
    logic [N_NEURONS*W-1:0] v_q;
    logic [N_NEURONS*W-1:0] i_snap_q;
    logic signed [W-1:0]    res_q;
    logic [N_NEURONS-1:0]   pend_q;
    logic [N_NEURONS-1:0]   spike_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   dp_req_q;
    logic [W-1:0]           dp_v_q;
    logic [W-1:0]           dp_i_q;

    logic [KW-1:0]          k_nxt_c;
    logic                   spike_hit_c;

    assign k_nxt_c     = k_q + KW'(1);
    // Signed compare: a result exactly at the threshold fires.
    assign spike_hit_c = (res_q >= VPEAK_S);

    // Scheduler FSM, register file and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            v_q      <= {N_NEURONS{VINIT_S}};
            i_snap_q <= '0;
            res_q    <= '0;
            pend_q   <= '0;
            spike_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dp_req_q <= 1'b0;
            dp_v_q   <= '0;
            dp_i_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // clear wins over a coincident step; that step is dropped.
                    if (clear) begin
                        v_q     <= {N_NEURONS{VINIT_S}};
                        spike_q <= '0;
                    end else if (step && enable) begin
                        i_snap_q <= i_syn_flat;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        dp_req_q <= 1'b1;
                        dp_v_q   <= v_q[W-1:0];
                        dp_i_q   <= i_syn_flat[W-1:0];
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Operands and request stay held until the datapath acks.
                    if (dp_ack) begin
                        res_q    <= dp_v_next;
                        dp_req_q <= 1'b0;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (spike_hit_c) begin
                        v_q[k_q*W +: W] <= VRESET_S;
                        pend_q[k_q]     <= 1'b1;
                    end else begin
                        v_q[k_q*W +: W] <= res_q;
                        pend_q[k_q]     <= 1'b0;
                    end
                    if (k_q == K_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        // Next slot is still untouched this step, so reading v_q is safe.
                        k_q      <= k_nxt_c;
                        dp_req_q <= 1'b1;
                        dp_v_q   <= v_q[k_nxt_c*W +: W];
                        dp_i_q   <= i_snap_q[k_nxt_c*W +: W];
                        state_q  <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    spike_q <= pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign spike_vec  = spike_q;
    assign v_mem_flat = v_q;
    assign dp_req     = dp_req_q;
    assign dp_v       = dp_v_q;
    assign dp_i       = dp_i_q;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// tb_qif_neuron_scheduler: scoreboard bench for qif_neuron_scheduler.
// A behavioural datapath (v + i with a programmable number of wait cycles)
// answers the request handshake. Each accepted step pushes its expected
// voltages, spikes and done latency. A negedge monitor pops one entry on
// every done pulse.
module tb_qif_neuron_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;
    localparam logic signed [W-1:0] M_VPEAK  = 8'sd50;
    localparam logic signed [W-1:0] M_VRESET = -8'sd20;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           step;
    logic           clear;
    logic [N*W-1:0] i_syn_flat;
    logic           busy;
    logic           done;
    logic [N-1:0]   spike_vec;
    logic [N*W-1:0] v_mem_flat;
    logic           dp_req;
    logic [W-1:0]   dp_v;
    logic [W-1:0]   dp_i;
    logic           dp_ack;
    logic [W-1:0]   dp_v_next;

    qif_neuron_scheduler #(
        .N_NEURONS(N), .W(W), .VPEAK(50), .VRESET(-20), .VINIT(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .step(step), .clear(clear),
        .i_syn_flat(i_syn_flat), .busy(busy), .done(done), .spike_vec(spike_vec),
        .v_mem_flat(v_mem_flat), .dp_req(dp_req), .dp_v(dp_v), .dp_i(dp_i),
        .dp_ack(dp_ack), .dp_v_next(dp_v_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] v;
        logic [N-1:0]   spk;
        int             lat;
        int             step_cyc;
    } exp_t;

    exp_t                sb[$];
    int                  n_vec = 0;
    int                  n_err = 0;
    int                  cyc = 0;
    int                  wait_cycles = 0;
    int                  req_cnt = 0;
    logic signed [W-1:0] mv [N];
    logic [W-1:0]        hold_v;
    logic [W-1:0]        hold_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: acks after wait_cycles, checks operands held while waiting.
    always @(negedge clk) begin
        if (dp_req && !reset) begin
            if (req_cnt == 0) begin
                hold_v = dp_v;
                hold_i = dp_i;
            end else begin
                check_val("dp_v_hold", 64'(dp_v), 64'(hold_v));
                check_val("dp_i_hold", 64'(dp_i), 64'(hold_i));
            end
            if (req_cnt == wait_cycles) begin
                dp_ack    = 1'b1;
                dp_v_next = dp_v + dp_i;
            end else begin
                dp_ack = 1'b0;
            end
            req_cnt++;
        end else begin
            dp_ack  = 1'b0;
            req_cnt = 0;
        end
    end

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("spike_vec", 64'(spike_vec), 64'(e.spk));
                for (int k = 0; k < int'(N); k++)
                    check_val($sformatf("v_slot%0d", k), 64'(v_mem_flat[k*W +: W]), 64'(e.v[k*W +: W]));
                check_val("done_latency", 64'(cyc - e.step_cyc), 64'(e.lat));
            end
        end
    end

    // Drive one step; when accepted, predict the outcome and push it.
    task automatic do_step(input logic [N*W-1:0] cur, input bit accepted);
        exp_t                e;
        logic signed [W-1:0] nv;
        @(negedge clk);
        i_syn_flat = cur;
        enable     = 1'b1;
        step       = 1'b1;
        if (accepted) begin
            e.spk = '0;
            for (int k = 0; k < int'(N); k++) begin
                nv = mv[k] + $signed(cur[k*W +: W]);
                if (nv >= M_VPEAK) begin
                    mv[k]    = M_VRESET;
                    e.spk[k] = 1'b1;
                end else begin
                    mv[k] = nv;
                end
                e.v[k*W +: W] = mv[k];
            end
            e.lat      = (wait_cycles + 2) * int'(N) + 1;
            e.step_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        step = 1'b0;
        // Inputs moving after acceptance must not affect the step.
        i_syn_flat = (N*W)'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check_val("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        @(negedge clk);
        check_val("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic do_clear(input bit with_step);
        @(negedge clk);
        clear = 1'b1;
        step  = with_step;
        @(negedge clk);
        clear = 1'b0;
        step  = 1'b0;
        for (int k = 0; k < int'(N); k++) mv[k] = '0;
        check_val("clear_v", 64'(v_mem_flat), 64'd0);
        check_val("clear_spike", 64'(spike_vec), 64'd0);
        check_val("clear_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rises;
        logic prev;
        reset      = 1'b1;
        enable     = 1'b0;
        step       = 1'b0;
        clear      = 1'b0;
        i_syn_flat = '0;
        dp_ack     = 1'b0;
        dp_v_next  = '0;
        for (int k = 0; k < int'(N); k++) mv[k] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_v", 64'(v_mem_flat), 64'd0);
        check_val("rst_spike", 64'(spike_vec), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_dp_req", 64'(dp_req), 64'd0);
        check_val("rst_dp_v", 64'(dp_v), 64'd0);
        check_val("rst_dp_i", 64'(dp_i), 64'd0);

        // Zero-wait datapath: basic accumulation, then slots 2 and 3 spike.
        wait_cycles = 0;
        do_step({8'd40, 8'd30, 8'd20, 8'd10}, 1'b1);
        wait_done();
        do_step({8'd40, 8'd30, 8'd20, 8'd10}, 1'b1);
        wait_done();
        check_val("spike_1100", 64'(spike_vec), 64'b1100);

        // Threshold boundary: slot 0 lands on exactly 50, slot 1 on 49.
        do_clear(1'b0);
        do_step({8'd0, 8'd0, 8'd40, 8'd40}, 1'b1);
        wait_done();
        do_step({8'd0, 8'd0, 8'd9, 8'd10}, 1'b1);
        wait_done();
        check_val("boundary_v0", 64'(v_mem_flat[W-1:0]), 64'(8'hEC));
        check_val("boundary_v1", 64'(v_mem_flat[2*W-1:W]), 64'd49);

        // Three wait cycles per neuron; a step pulse mid-run must be ignored.
        wait_cycles = 3;
        do_step({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
        repeat (6) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_done();

        // enable low: step not accepted.
        wait_cycles = 0;
        @(negedge clk);
        enable = 1'b0;
        step   = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check_val("disabled_busy", 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
        enable = 1'b1;

        // clear with step: clear wins, step dropped.
        do_clear(1'b1);
        repeat (12) @(negedge clk);
        check_val("clr_step_busy", 64'(busy), 64'd0);

        // Build non-zero state, then reset while servicing neuron 2.
        do_step({8'd5, 8'd5, 8'd5, 8'd5}, 1'b1);
        wait_done();
        wait_cycles = 1;
        do_step({8'd7, 8'd7, 8'd7, 8'd7}, 1'b0);
        rises = 1;
        prev  = dp_req;
        for (int t = 0; t < 100 && rises < 3; t++) begin
            @(negedge clk);
            if (dp_req && !prev) rises++;
            prev = dp_req;
        end
        check_val("reach_k2", 64'(rises), 64'd3);
        reset = 1'b1;
        #1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_dp_req", 64'(dp_req), 64'd0);
        check_val("midrst_v", 64'(v_mem_flat), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < int'(N); k++) mv[k] = '0;
        repeat (30) @(negedge clk);
        check_val("midrst_idle", 64'(busy), 64'd0);

        // Spike after reset, then clear restores VINIT and spike_vec.
        wait_cycles = 0;
        do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b1);
        wait_done();
        check_val("spike_0001", 64'(spike_vec), 64'b0001);
        do_clear(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
